llc_port_arbiter: RTL and testbench

LLC_PORT_ARBITER -- requirements
Module: llc_port_arbiter

---
 rtl/llc_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_llc_port_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_port_arbiter.sv
// ============================================================================
// llc_port_arbiter : round-robin L1I/L1D arbiter in front of a shared LLC port
// Revision: 1.0
// ============================================================================
`default_nettype none

module llc_port_arbiter #(
    parameter int PADDR_BITS = 64,
    parameter int B          = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_in,

    input  logic                  i_valid_in,
    output logic                  i_ready_out,
    input  logic [PADDR_BITS-1:0] i_addr_in,
    output logic                  i_valid_out,
    input  logic                  i_ready_in,
    output logic [PADDR_BITS-1:0] i_addr_out,
    output logic [8*B-1:0]        i_value_out,

    input  logic                  d_valid_in,
    output logic                  d_ready_out,
    input  logic [PADDR_BITS-1:0] d_addr_in,
    input  logic [8*B-1:0]        d_value_in,
    input  logic                  d_we_in,
    output logic                  d_valid_out,
    input  logic                  d_ready_in,
    output logic [PADDR_BITS-1:0] d_addr_out,
    output logic [8*B-1:0]        d_value_out,

    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [8*B-1:0]        lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [8*B-1:0]        lc_value_in
);

    localparam int LINE_BITS = 8 * B;
    localparam int OFF_BITS  = $clog2(B);

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_REQ  = 2'd1,
        WAIT_RESP = 2'd2,
        SEND_RESP = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;

    logic                    i_valid_q, i_valid_d;
    logic [PADDR_BITS-1:0]   i_addr_q, i_addr_d;
    logic [LINE_BITS-1:0]    i_value_q, i_value_d;
    logic                    d_valid_q, d_valid_d;
    logic [PADDR_BITS-1:0]   d_addr_q, d_addr_d;
    logic [LINE_BITS-1:0]    d_value_q, d_value_d;

    logic                    lc_valid_q, lc_valid_d;
    logic [PADDR_BITS-1:0]   lc_addr_q, lc_addr_d;
    logic [LINE_BITS-1:0]    lc_value_q, lc_value_d;
    logic                    lc_we_q, lc_we_d;
    logic                    lc_ready_q, lc_ready_d;

    logic                    grant_i;
    logic                    blk_match;

    assign i_valid_out  = i_valid_q;
    assign i_addr_out   = i_addr_q;
    assign i_value_out  = i_value_q;
    assign d_valid_out  = d_valid_q;
    assign d_addr_out   = d_addr_q;
    assign d_value_out  = d_value_q;
    assign lc_valid_out = lc_valid_q;
    assign lc_addr_out  = lc_addr_q;
    assign lc_value_out = lc_value_q;
    assign lc_we_out    = lc_we_q;
    assign lc_ready_out = lc_ready_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        i_valid_d    = i_valid_q;
        i_addr_d     = i_addr_q;
        i_value_d    = i_value_q;
        d_valid_d    = d_valid_q;
        d_addr_d     = d_addr_q;
        d_value_d    = d_value_q;
        lc_valid_d   = lc_valid_q;
        lc_addr_d    = lc_addr_q;
        lc_value_d   = lc_value_q;
        lc_we_d      = lc_we_q;
        lc_ready_d   = lc_ready_q;
        i_ready_out  = 1'b0;
        d_ready_out  = 1'b0;

        // On a tie L1I wins only if L1D was served last.
        grant_i   = i_valid_in && (!d_valid_in || (last_grant_q == OWNER_D));
        blk_match = (lc_addr_in[PADDR_BITS-1:OFF_BITS] == lc_addr_q[PADDR_BITS-1:OFF_BITS]);

        case (state_q)
            IDLE: begin
                i_ready_out = grant_i;
                d_ready_out = d_valid_in && !grant_i;
                if (i_valid_in || d_valid_in) begin
                    owner_d      = grant_i ? OWNER_I : OWNER_D;
                    last_grant_d = grant_i ? OWNER_I : OWNER_D;
                    lc_valid_d   = 1'b1;
                    lc_addr_d    = grant_i ? i_addr_in : d_addr_in;
                    lc_value_d   = grant_i ? '0 : d_value_in;
                    lc_we_d      = grant_i ? 1'b0 : d_we_in;
                    state_d      = SEND_REQ;
                end
            end
            SEND_REQ: begin
                if (lc_ready_in) begin
                    lc_valid_d = 1'b0;
                    if (lc_we_q) begin
                        state_d = IDLE;
                    end else begin
                        lc_ready_d = 1'b1;
                        state_d    = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // Responses for other blocks are consumed and dropped.
                if (lc_valid_in && blk_match) begin
                    lc_ready_d = 1'b0;
                    state_d    = SEND_RESP;
                    if (owner_q == OWNER_I) begin
                        i_valid_d = 1'b1;
                        i_addr_d  = lc_addr_in;
                        i_value_d = lc_value_in;
                    end else begin
                        d_valid_d = 1'b1;
                        d_addr_d  = lc_addr_in;
                        d_value_d = lc_value_in;
                    end
                end
            end
            SEND_RESP: begin
                if (owner_q == OWNER_I) begin
                    if (i_ready_in) begin
                        i_valid_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else begin
                    if (d_ready_in) begin
                        d_valid_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_I;
            last_grant_q <= OWNER_D;
            i_valid_q    <= 1'b0;
            i_addr_q     <= '0;
            i_value_q    <= '0;
            d_valid_q    <= 1'b0;
            d_addr_q     <= '0;
            d_value_q    <= '0;
            lc_valid_q   <= 1'b0;
            lc_addr_q    <= '0;
            lc_value_q   <= '0;
            lc_we_q      <= 1'b0;
            lc_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            i_valid_q    <= i_valid_d;
            i_addr_q     <= i_addr_d;
            i_value_q    <= i_value_d;
            d_valid_q    <= d_valid_d;
            d_addr_q     <= d_addr_d;
            d_value_q    <= d_value_d;
            lc_valid_q   <= lc_valid_d;
            lc_addr_q    <= lc_addr_d;
            lc_value_q   <= lc_value_d;
            lc_we_q      <= lc_we_d;
            lc_ready_q   <= lc_ready_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_llc_port_arbiter.sv
// ============================================================================
// tb_llc_port_arbiter : directed and randomized checks of llc_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_llc_port_arbiter;

    localparam int PA = 64;
    localparam int BB = 64;
    localparam int LW = 8 * BB;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          i_valid_in, i_ready_out, i_valid_out, i_ready_in;
    logic [PA-1:0] i_addr_in, i_addr_out;
    logic [LW-1:0] i_value_out;
    logic          d_valid_in, d_ready_out, d_we_in, d_valid_out, d_ready_in;
    logic [PA-1:0] d_addr_in, d_addr_out;
    logic [LW-1:0] d_value_in, d_value_out;
    logic          lc_valid_out, lc_ready_in, lc_we_out, lc_valid_in, lc_ready_out;
    logic [PA-1:0] lc_addr_out, lc_addr_in;
    logic [LW-1:0] lc_value_out, lc_value_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    llc_port_arbiter #(.PADDR_BITS(PA), .B(BB)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .i_valid_in(i_valid_in), .i_ready_out(i_ready_out), .i_addr_in(i_addr_in),
        .i_valid_out(i_valid_out), .i_ready_in(i_ready_in),
        .i_addr_out(i_addr_out), .i_value_out(i_value_out),
        .d_valid_in(d_valid_in), .d_ready_out(d_ready_out), .d_addr_in(d_addr_in),
        .d_value_in(d_value_in), .d_we_in(d_we_in),
        .d_valid_out(d_valid_out), .d_ready_in(d_ready_in),
        .d_addr_out(d_addr_out), .d_value_out(d_value_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in),
        .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
        .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out),
        .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in)
    );

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid_in = 1'b0; i_addr_in = '0; i_ready_in = 1'b0;
        d_valid_in = 1'b0; d_addr_in = '0; d_value_in = '0; d_we_in = 1'b0; d_ready_in = 1'b0;
        lc_ready_in = 1'b0; lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        idle_inputs();
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({i_valid_out, d_valid_out, lc_valid_out, lc_ready_out, lc_we_out, i_ready_out, d_ready_out} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {i_valid_out, d_valid_out, lc_valid_out, lc_ready_out, lc_we_out, i_ready_out, d_ready_out});
        end
        n_checks++;
        if ({i_addr_out, d_addr_out, lc_addr_out} !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 0", {i_addr_out, d_addr_out, lc_addr_out});
        end
        n_checks++;
        if ({i_value_out, d_value_out, lc_value_out} !== '0) begin
            n_fail++; $display("FAIL reset_value: got nonzero value outputs expected 0");
        end
    endtask

    task automatic test_single_read();
        logic [LW-1:0] v;
        v = {BB{8'hAB}};
        do_reset();
        i_valid_in = 1'b1; i_addr_in = 64'h1000; i_ready_in = 1'b0;
        #1;
        n_checks++;
        if ({i_ready_out, d_ready_out} !== 2'b10) begin
            n_fail++; $display("FAIL rd_ready: got %b expected 10", {i_ready_out, d_ready_out});
        end
        step();
        i_valid_in = 1'b0; i_addr_in = 64'hDEAD_0000;
        n_checks++;
        if ({lc_valid_out, lc_we_out, lc_ready_out} !== 3'b100 || lc_addr_out !== 64'h1000) begin
            n_fail++; $display("FAIL rd_lc_req: got v/we/rdy=%b addr=%h expected 100 1000",
                               {lc_valid_out, lc_we_out, lc_ready_out}, lc_addr_out);
        end
        lc_ready_in = 1'b1; lc_valid_in = 1'b1; lc_addr_in = 64'h1000; lc_value_in = v;
        step();
        lc_ready_in = 1'b0;
        n_checks++;
        if ({lc_valid_out, lc_ready_out} !== 2'b01) begin
            n_fail++; $display("FAIL rd_wait: got %b expected 01", {lc_valid_out, lc_ready_out});
        end
        step();
        lc_valid_in = 1'b0;
        n_checks++;
        if (i_valid_out !== 1'b1) begin
            n_fail++; $display("FAIL read_latency: i_valid_out got %b expected 1", i_valid_out);
        end
        n_checks++;
        if (i_addr_out !== 64'h1000 || i_value_out !== v || d_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL rd_resp: got addr=%h dv=%b expected 1000 0", i_addr_out, d_valid_out);
        end
        i_ready_in = 1'b1;
        step();
        i_ready_in = 1'b0;
        n_checks++;
        if (i_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL rd_done: i_valid_out got %b expected 0", i_valid_out);
        end
    endtask

    task automatic test_round_robin();
        bit held_ok;
        do_reset();
        i_valid_in = 1'b1; i_addr_in = 64'h2000;
        d_valid_in = 1'b1; d_addr_in = 64'h3000; d_we_in = 1'b0;
        #1;
        n_checks++;
        if ({i_ready_out, d_ready_out} !== 2'b10) begin
            n_fail++; $display("FAIL rr_first_tie: got %b expected 10", {i_ready_out, d_ready_out});
        end
        step();
        i_valid_in = 1'b0;
        held_ok = (d_ready_out == 1'b0);
        lc_ready_in = 1'b1;
        step();
        lc_ready_in = 1'b0;
        held_ok &= (d_ready_out == 1'b0);
        lc_valid_in = 1'b1; lc_addr_in = 64'h2000; lc_value_in = rand_line();
        step();
        lc_valid_in = 1'b0;
        i_ready_in = 1'b1;
        #1;
        held_ok &= (d_ready_out == 1'b0);
        step();
        i_ready_in = 1'b0;
        n_checks++;
        if (held_ok !== 1'b1) begin
            n_fail++; $display("FAIL rr_d_held: got %b expected 1", held_ok);
        end
        n_checks++;
        if ({i_ready_out, d_ready_out} !== 2'b01) begin
            n_fail++; $display("FAIL rr_d_grant: got %b expected 01", {i_ready_out, d_ready_out});
        end
        step();
        d_valid_in = 1'b0;
        n_checks++;
        if (lc_addr_out !== 64'h3000) begin
            n_fail++; $display("FAIL rr_d_lc_addr: got %h expected 3000", lc_addr_out);
        end
        lc_ready_in = 1'b1;
        step();
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b1; lc_addr_in = 64'h3000;
        step();
        lc_valid_in = 1'b0;
        n_checks++;
        if ({i_valid_out, d_valid_out} !== 2'b01) begin
            n_fail++; $display("FAIL rr_d_resp: got %b expected 01", {i_valid_out, d_valid_out});
        end
        d_ready_in = 1'b1;
        step();
        d_ready_in = 1'b0;
        i_valid_in = 1'b1; i_addr_in = 64'h2100;
        d_valid_in = 1'b1; d_addr_in = 64'h3100;
        #1;
        n_checks++;
        if ({i_ready_out, d_ready_out} !== 2'b10) begin
            n_fail++; $display("FAIL rr_second_tie: got %b expected 10", {i_ready_out, d_ready_out});
        end
    endtask

    task automatic test_write();
        logic [LW-1:0] v;
        bit quiet;
        v = {BB{8'h55}};
        do_reset();
        d_valid_in = 1'b1; d_addr_in = 64'h4000; d_we_in = 1'b1; d_value_in = v;
        step();
        d_valid_in = 1'b0; d_value_in = '0;
        n_checks++;
        if ({lc_valid_out, lc_we_out} !== 2'b11 || lc_value_out !== v || lc_addr_out !== 64'h4000) begin
            n_fail++; $display("FAIL wr_lc_req: got v/we=%b addr=%h expected 11 4000", {lc_valid_out, lc_we_out}, lc_addr_out);
        end
        lc_ready_in = 1'b1;
        step();
        lc_ready_in = 1'b0;
        n_checks++;
        if ({lc_valid_out, lc_ready_out} !== 2'b00) begin
            n_fail++; $display("FAIL wr_done: got %b expected 00", {lc_valid_out, lc_ready_out});
        end
        quiet = 1'b1;
        i_valid_in = 1'b1; i_addr_in = 64'h4400;
        #1;
        n_checks++;
        if (i_ready_out !== 1'b1) begin
            n_fail++; $display("FAIL wr_back_idle: i_ready_out got %b expected 1", i_ready_out);
        end
        i_valid_in = 1'b0;
        repeat (3) begin
            step();
            quiet &= (d_valid_out == 1'b0);
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++; $display("FAIL wr_no_resp: got %b expected 1", quiet);
        end
    endtask

    task automatic test_resp_stall();
        logic [LW-1:0] v;
        bit stable;
        v = rand_line();
        do_reset();
        i_valid_in = 1'b1; i_addr_in = 64'h1000;
        step();
        i_valid_in = 1'b0;
        lc_ready_in = 1'b1;
        step();
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b1; lc_addr_in = 64'h1008; lc_value_in = v;
        step();
        lc_valid_in = 1'b0; lc_value_in = '0;
        d_valid_in = 1'b1; d_addr_in = 64'h9000; d_we_in = 1'b0;
        stable = 1'b1;
        repeat (5) begin
            #1;
            stable &= (i_valid_out == 1'b1) && (i_addr_out == 64'h1008) && (i_value_out == v) && (d_ready_out == 1'b0);
            step();
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++; $display("FAIL stall_stable: got %b expected 1", stable);
        end
        i_ready_in = 1'b1;
        step();
        i_ready_in = 1'b0;
        #1;
        n_checks++;
        if ({i_valid_out, d_ready_out} !== 2'b01) begin
            n_fail++; $display("FAIL stall_release: got %b expected 01", {i_valid_out, d_ready_out});
        end
    endtask

    task automatic test_mismatch();
        logic [LW-1:0] v1, v2;
        v1 = rand_line();
        v2 = rand_line();
        do_reset();
        d_valid_in = 1'b1; d_addr_in = 64'h5000; d_we_in = 1'b0;
        step();
        d_valid_in = 1'b0;
        lc_ready_in = 1'b1;
        step();
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b1; lc_addr_in = 64'h5040; lc_value_in = v1;
        step();
        n_checks++;
        if ({lc_ready_out, d_valid_out, i_valid_out} !== 3'b100) begin
            n_fail++; $display("FAIL mm_discard: got %b expected 100", {lc_ready_out, d_valid_out, i_valid_out});
        end
        lc_addr_in = 64'h5000; lc_value_in = v2;
        step();
        lc_valid_in = 1'b0;
        n_checks++;
        if (d_valid_out !== 1'b1 || d_addr_out !== 64'h5000 || d_value_out !== v2) begin
            n_fail++; $display("FAIL mm_resp: got v=%b addr=%h expected 1 5000", d_valid_out, d_addr_out);
        end
        d_ready_in = 1'b1;
        step();
        d_ready_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] v;
        v = rand_line();
        do_reset();
        i_valid_in = 1'b1; i_addr_in = 64'h1234_5000;
        step();
        i_valid_in = 1'b0;
        lc_ready_in = 1'b1;
        step();
        lc_ready_in = 1'b0;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        n_checks++;
        if ({i_valid_out, d_valid_out, lc_valid_out, lc_ready_out, lc_we_out} !== 5'b0 ||
            lc_addr_out !== '0 || lc_value_out !== '0 || i_addr_out !== '0) begin
            n_fail++; $display("FAIL midrst_zero: got flags=%b lc_addr=%h expected 0 0",
                               {i_valid_out, d_valid_out, lc_valid_out, lc_ready_out, lc_we_out}, lc_addr_out);
        end
        i_valid_in = 1'b1; i_addr_in = 64'h6000;
        step();
        i_valid_in = 1'b0;
        lc_ready_in = 1'b1;
        step();
        lc_ready_in = 1'b0;
        lc_valid_in = 1'b1; lc_addr_in = 64'h6000; lc_value_in = v;
        step();
        lc_valid_in = 1'b0;
        n_checks++;
        if (i_valid_out !== 1'b1 || i_addr_out !== 64'h6000 || i_value_out !== v) begin
            n_fail++; $display("FAIL midrst_read: got v=%b addr=%h expected 1 6000", i_valid_out, i_addr_out);
        end
        i_ready_in = 1'b1;
        step();
        i_ready_in = 1'b0;
    endtask

    // Transaction-level model: pending requests per port, a last-served flag
    // for the round-robin tie-break, and the expected LLC request/response.
    task automatic test_random();
        bit            pi, pd, dwe, g_d, lg_d, ok;
        logic [PA-1:0] ia, da, ea, ra;
        logic [LW-1:0] dv, rv;
        logic          ewe;
        do_reset();
        pi = 1'b0; pd = 1'b0; lg_d = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (!pi && $urandom_range(1, 0) == 1) begin
                pi = 1'b1; ia = {$urandom, $urandom};
                i_valid_in = 1'b1; i_addr_in = ia;
            end
            if (!pd && ($urandom_range(1, 0) == 1 || !pi)) begin
                pd = 1'b1; da = {$urandom, $urandom}; dwe = 1'($urandom_range(1, 0)); dv = rand_line();
                d_valid_in = 1'b1; d_addr_in = da; d_we_in = dwe; d_value_in = dv;
            end
            g_d = pd && (!pi || !lg_d);
            #1;
            n_checks++;
            if ({i_ready_out, d_ready_out} !== {!g_d, g_d}) begin
                n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", n, {i_ready_out, d_ready_out}, {!g_d, g_d});
            end
            ea  = g_d ? da : ia;
            ewe = g_d ? dwe : 1'b0;
            step();
            if (g_d) begin d_valid_in = 1'b0; pd = 1'b0; end
            else     begin i_valid_in = 1'b0; pi = 1'b0; end
            lg_d = g_d;
            ok = 1'b1;
            repeat ($urandom_range(3, 0)) begin
                ok &= (lc_valid_out == 1'b1) && (lc_addr_out == ea) && (i_ready_out == 1'b0) && (d_ready_out == 1'b0);
                step();
            end
            n_checks++;
            if (ok !== 1'b1 || lc_valid_out !== 1'b1 || lc_addr_out !== ea || lc_we_out !== ewe ||
                (ewe && lc_value_out !== dv)) begin
                n_fail++; $display("FAIL rnd_lc_req[%0d]: got v=%b addr=%h we=%b hold=%b expected 1 %h %b 1",
                                   n, lc_valid_out, lc_addr_out, lc_we_out, ok, ea, ewe);
            end
            lc_ready_in = 1'b1;
            step();
            lc_ready_in = 1'b0;
            if (ewe) begin
                n_checks++;
                if ({lc_valid_out, lc_ready_out, i_valid_out, d_valid_out} !== 4'b0) begin
                    n_fail++; $display("FAIL rnd_wr_end[%0d]: got %b expected 0000", n,
                                       {lc_valid_out, lc_ready_out, i_valid_out, d_valid_out});
                end
            end else begin
                ok = 1'b1;
                repeat ($urandom_range(2, 0)) begin
                    lc_valid_in = 1'b1;
                    lc_addr_in  = ea + 64'(64 * $urandom_range(8, 1));
                    lc_value_in = rand_line();
                    step();
                    ok &= (lc_ready_out == 1'b1) && (i_valid_out == 1'b0) && (d_valid_out == 1'b0);
                end
                ra = {ea[PA-1:6], 6'($urandom_range(63, 0))};
                rv = rand_line();
                lc_valid_in = 1'b1; lc_addr_in = ra; lc_value_in = rv;
                step();
                lc_valid_in = 1'b0;
                n_checks++;
                if (ok !== 1'b1 || {i_valid_out, d_valid_out} !== {!g_d, g_d} ||
                    (g_d ? d_addr_out : i_addr_out) !== ra || (g_d ? d_value_out : i_value_out) !== rv) begin
                    n_fail++; $display("FAIL rnd_resp[%0d]: got v=%b addr=%h discard=%b expected %b %h 1",
                                       n, {i_valid_out, d_valid_out}, g_d ? d_addr_out : i_addr_out, ok, {!g_d, g_d}, ra);
                end
                ok = 1'b1;
                repeat ($urandom_range(3, 0)) begin
                    step();
                    ok &= ((g_d ? d_valid_out : i_valid_out) == 1'b1) &&
                          ((g_d ? d_value_out : i_value_out) == rv) && (i_ready_out == 1'b0) && (d_ready_out == 1'b0);
                end
                if (g_d) d_ready_in = 1'b1; else i_ready_in = 1'b1;
                step();
                d_ready_in = 1'b0; i_ready_in = 1'b0;
                n_checks++;
                if (ok !== 1'b1 || {i_valid_out, d_valid_out} !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_resp_done[%0d]: got v=%b hold=%b expected 00 1",
                                       n, {i_valid_out, d_valid_out}, ok);
                end
            end
        end
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_resp_stall();
        test_mismatch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
